// File: rtl/req_onehot_arbiter.sv
// req_onehot_arbiter
// Captures rising edges on eight request lines into a pending bitmap and
// issues one-hot grants from it in round-robin order starting at ptr.
// A grant is held until acknowledged; an IDLE cycle always separates grants.
//
// Handshake: grant/grant_valid are registered. While grant_valid=1 the grant
// is held stable; the consumer completes it by holding grant_ack=1 at a rising
// edge. grant_ack is ignored while grant_valid=0.
module req_onehot_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       grant_ack,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [7:0] pending,
    output logic       overflow,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] req_q;
    logic [2:0] ptr;

    logic [7:0] evt;
    logic [7:0] clr;
    logic [7:0] pending_nxt;
    logic       lost;
    logic       sel_found;
    logic [2:0] sel_idx;
    logic [2:0] scan_idx;
    logic [2:0] granted_idx;

    // 1 while a grant is live.
    assign dbg_state = (state == GRANT);

    // Request edge detection and pending-bit bookkeeping; a new edge beats an ack-clear.
    always_comb begin
        evt         = req & ~req_q;
        clr         = (state == GRANT && grant_ack) ? grant : 8'h00;
        lost        = |(evt & pending & ~clr);
        pending_nxt = (pending & ~clr) | evt;
    end

    // Round-robin search: first set pending bit at ptr, ptr+1, ... with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        scan_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr + 3'(i);
            if (!sel_found && pending[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Index of the currently granted bit (grant is one-hot or zero).
    always_comb begin
        granted_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (grant[i]) begin
                granted_idx = 3'(i);
            end
        end
    end

    // State, grant registers, pending bitmap, sticky overflow and rotation pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            pending     <= 8'h00;
            overflow    <= 1'b0;
            ptr         <= 3'd0;
            req_q       <= 8'h00;
        end else begin
            req_q   <= req;
            pending <= pending_nxt;
            if (lost) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable && sel_found) begin
                        grant       <= 8'h01 << sel_idx;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end else begin
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (grant_ack) begin
                        ptr         <= granted_idx + 3'd1;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= 8'h00;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Testbench for req_onehot_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_req_onehot_arbiter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] req;
    logic       grant_ack;
    logic [7:0] grant;
    logic       grant_valid;
    logic [7:0] pending;
    logic       overflow;
    logic       dbg_state;

    int n_checks;
    int n_fail;

    // reference model state
    bit [7:0] m_pend;
    bit [7:0] m_prev;
    int       m_ptr;
    int       m_gidx;   // -1 when no grant is live
    bit       m_ovf;
    logic [7:0] exp_q[$];
    logic     prev_gv;

    req_onehot_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req        (req),
        .grant_ack  (grant_ack),
        .grant      (grant),
        .grant_valid(grant_valid),
        .pending    (pending),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the behavioural model.
    task automatic model_edge(input logic r_rst, input logic r_en, input logic [7:0] r_req,
                              input logic r_ack);
        bit [7:0] evt;
        bit [7:0] old_pend;
        int       cleared;
        int       new_g;
        bit       found;
        int       k;
        if (r_rst) begin
            m_pend = '0;
            m_prev = '0;
            m_ptr  = 0;
            m_gidx = -1;
            m_ovf  = 0;
            exp_q.delete();
            return;
        end
        evt      = r_req & ~m_prev;
        old_pend = m_pend;
        cleared  = -1;
        new_g    = m_gidx;
        if (m_gidx >= 0) begin
            if (r_ack) begin
                cleared = m_gidx;
                m_ptr   = (m_gidx + 1) % 8;
                new_g   = -1;
            end
        end else if (r_en && old_pend != 0) begin
            found = 0;
            for (int i = 0; i < 8; i++) begin
                k = (m_ptr + i) % 8;
                if (!found && old_pend[k]) begin
                    found = 1;
                    new_g = k;
                end
            end
            exp_q.push_back(8'h01 << new_g);
        end
        for (int i = 0; i < 8; i++) begin
            if (evt[i] && old_pend[i] && i != cleared) m_ovf = 1;
            m_pend[i] = (old_pend[i] && i != cleared) || evt[i];
        end
        m_prev = r_req;
        m_gidx = new_g;
    endtask

    task automatic compare_all();
        logic [7:0] exp_g;
        logic [7:0] sb_g;
        exp_g = 8'h00;
        if (m_gidx >= 0) exp_g[m_gidx] = 1'b1;
        check_eq("grant", grant, exp_g);
        check_eq("grant_valid", grant_valid, (m_gidx >= 0));
        check_eq("pending", pending, m_pend);
        check_eq("overflow", overflow, m_ovf);
        check_eq("dbg_state", dbg_state, (m_gidx >= 0));
        check_eq("onehot0", $onehot0(grant), 1);
        if (grant_valid && !prev_gv) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_empty", 1, 0);
            end else begin
                sb_g = exp_q.pop_front();
                check_eq("sb_grant", grant, sb_g);
            end
        end
        prev_gv = grant_valid;
    endtask

    // driver: apply inputs away from the edge, advance model, sample #1 after
    task automatic step(input logic r_rst, input logic r_en, input logic [7:0] r_req,
                        input logic r_ack);
        @(negedge clk);
        rst       = r_rst;
        enable    = r_en;
        req       = r_req;
        grant_ack = r_ack;
        @(posedge clk);
        model_edge(r_rst, r_en, r_req, r_ack);
        #1;
        if (r_rst) prev_gv = 1'b0;
        compare_all();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        prev_gv   = 1'b0;
        m_gidx    = -1;
        rst       = 1'b1;
        enable    = 1'b0;
        req       = 8'h00;
        grant_ack = 1'b0;

        // reset state
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        check_eq("rst_grant", grant, 8'h00);
        check_eq("rst_pending", pending, 8'h00);
        check_eq("rst_overflow", overflow, 0);

        // single request, grant, ack
        step(0, 1, 8'h04, 0);
        check_eq("p1_pending", pending, 8'h04);
        check_eq("p1_gv_early", grant_valid, 0);
        step(0, 1, 8'h00, 0);
        check_eq("p1_grant", grant, 8'h04);
        step(0, 1, 8'h00, 1);
        check_eq("p1_ack_grant", grant, 8'h00);
        check_eq("p1_ack_pending", pending, 8'h00);

        // ptr now 3: pending 09 grants 08 then wraps to 01; hold 5 cycles
        step(0, 1, 8'h09, 0);
        step(0, 1, 8'h00, 0);
        check_eq("wrap_first", grant, 8'h08);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'h00, 0);
            check_eq("wrap_hold", grant, 8'h08);
        end
        step(0, 1, 8'h00, 1);
        step(0, 1, 8'h00, 0);
        check_eq("wrap_second", grant, 8'h01);
        step(0, 1, 8'h00, 1);

        // two simultaneous requests from ptr=0
        step(1, 1, 8'h00, 0);
        step(0, 1, 8'h81, 0);
        step(0, 1, 8'h00, 0);
        check_eq("dual_first", grant, 8'h01);
        step(0, 1, 8'h00, 1);
        check_eq("dual_idle_gv", grant_valid, 0);
        step(0, 1, 8'h00, 0);
        check_eq("dual_second", grant, 8'h80);
        step(0, 1, 8'h00, 1);
        check_eq("dual_pending", pending, 8'h00);

        // enable low holds the request pending; ack in IDLE ignored
        step(0, 0, 8'h10, 1);
        step(0, 0, 8'h00, 1);
        check_eq("en0_pending", pending, 8'h10);
        check_eq("en0_gv", grant_valid, 0);
        step(0, 1, 8'h00, 0);
        check_eq("en1_grant", grant, 8'h10);
        step(0, 0, 8'h00, 0);
        check_eq("en0_keep", grant, 8'h10);
        step(0, 0, 8'h00, 1);

        // overflow: second edge on a live, pending bit
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h00, 0);
        check_eq("ovf_grant", grant, 8'h02);
        step(0, 1, 8'h02, 0);
        check_eq("ovf_set", overflow, 1);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 1);

        // fresh edge coinciding with ack-clear: set wins, no overflow
        step(1, 1, 8'h00, 0);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h02, 1);
        check_eq("race_pending", pending, 8'h02);
        check_eq("race_overflow", overflow, 0);
        step(0, 0, 8'h00, 0);

        // reset in GRANT, req held through reset
        step(0, 1, 8'h20, 0);
        check_eq("rg_pending", pending, 8'h22);
        step(0, 1, 8'h00, 0);
        check_eq("rg_gv", grant_valid, 1);
        step(1, 1, 8'h01, 0);
        check_eq("rg_grant0", grant, 8'h00);
        check_eq("rg_pend0", pending, 8'h00);
        step(1, 1, 8'h01, 0);
        step(0, 0, 8'h01, 0);
        check_eq("rg_held_evt", pending, 8'h01);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic       r_rst;
            logic       r_en;
            logic [7:0] r_req;
            logic       r_ack;
            r_rst = ($urandom_range(0, 249) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_req = 8'h00;
            for (int b = 0; b < 8; b++) r_req[b] = ($urandom_range(0, 5) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            step(r_rst, r_en, r_req, r_ack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
